s2mm_burst_scheduler: RTL and testbench
=======================================

# s2mm_burst_scheduler

Two-channel burst scheduler placed in front of `s2mm_ram_writer`. It merges two AXI-Stream sources into the writer's single stream input, switching between them only at 16-beat burst boundaries. It also drives the writer's `address` input with a per-channel ring-buffer address, so each source fills its own circular region in DDR. Software reads back per-channel write pointers and wrap counters to locate fresh data.

## Interface
- `AXI_ADDR_WIDTH`, 32, width of addresses and pointers
- `AXIS_TDATA_WIDTH`, 32, stream data width
- `BURST_LEN`, 16, beats per burst; must match the writer's burst length
- `BYTES_PER_BEAT`, 4, bytes written per beat (AXI_DATA_WIDTH/8)

- `aclk` in 1: clock
- `aresetn` in 1: reset, synchronous, active-low; clock `aclk`
- `enable` in 1: allows new grants
- `ch0_base`, `ch1_base` in AXI_ADDR_WIDTH: ring base address; must be aligned to the ring size
- `ch0_size_log2`, `ch1_size_log2` in 5: ring size is 2^n bytes
- `s0_axis_tdata/tvalid/tready`, `s1_axis_tdata/tvalid/tready`: slave streams
- `m_axis_tdata/tvalid/tready`: master stream to the writer
- `address` out AXI_ADDR_WIDTH: burst start address, to the writer
- `ch0_wptr`, `ch1_wptr` out AXI_ADDR_WIDTH: byte offset of the next burst in each ring
- `ch0_wraps`, `ch1_wraps` out 8: ring wrap counters
- `grant` out 2: one-hot indicator of the active channel; 0 when idle

## Operation
- FSM states: IDLE, BURST.
- **IDLE** (with `enable`=1):
  - Choose a channel whose tvalid=1.
  - If both are valid, choose the channel not granted last (round-robin; after reset, ch0 wins).
  - Register `grant`.
  - Latch `address` = base_sel + wptr_sel, modulo 2^AXI_ADDR_WIDTH.
  - Clear the beat counter and go to BURST.
- **BURST**:
  - `m_axis_tdata`/`tvalid` mirror the selected slave.
  - The selected tready = `m_axis_tready`; the other tready = 0.
  - Each handshake increments a 4-bit beat counter.
  - The handshake with counter = BURST_LEN-1 commits the burst:
    - wptr_sel = (wptr_sel + BURST_LEN*BYTES_PER_BEAT) & (2^size−1).
    - If the result is 0, wraps_sel increments (8-bit, rolls over).
    - `grant` goes to 0 and the FSM returns to IDLE.
- Effective size is clamped to [log2(BURST_LEN*BYTES_PER_BEAT), AXI_ADDR_WIDTH−1]. With the defaults the minimum is 6 (64 B).
- Base and size are sampled only at grant. Changes during a burst take effect at the next grant.
- `enable` falling during BURST: the burst completes, then no new grant is issued.
- `enable` rising edge (registered 0→1): both wptr and wraps clear to 0.
- A stalled source (tvalid low mid-burst) holds the grant indefinitely; no timeout.
- **Reset values:**
  - state IDLE, `grant`=0, `address`=0
  - wptrs 0, wraps 0, round-robin pointer favours ch0
  - all tready=0, `m_axis_tvalid`=0
- Reset mid-burst abandons the burst. The partial burst is not committed, and wptr is unchanged by it because reset clears it anyway.

## Timing
- Grant latency: tvalid seen in IDLE → `grant`/`address` registered next cycle; first beat can transfer in that cycle.
- The data path is combinational pass-through with zero latency.
- `address` is stable for the whole burst, including the first beat, which the writer uses as the burst address.
- One mandatory IDLE cycle separates consecutive bursts, giving a maximum throughput of 16/17.
- wptr/wraps update in the cycle after the final handshake. They are visible to software only after the burst has fully entered the writer.

## Structure
- Package `s2mm_sched_pkg`:
  - state enum {IDLE, BURST}
  - `BURST_BYTES` localparam
  - clamp function for the size field
- Sub-module `s2mm_ring_pointer`, instantiated once per channel:
  - holds wptr and wraps
  - inputs: commit, clear, size_log2
  - outputs: wptr, wraps

## Test plan
- ch0 only, base 0x1000_0000, size 8: 5 bursts of 16 beats → `address` sequence 0x1000_0000, _0040, _0080, _00C0, _0000; ch0_wraps=1; ch0_wptr=0x40.
- Both channels continuously valid → `grant` alternates 01,10,01,10. Each granted burst carries exactly 16 beats from one source, with no interleaving.
- ch1 drops tvalid for 10 cycles after beat 5 → ch0 stays blocked (tready=0) and ch1 retains the grant until beat 16.
- `m_axis_tready` toggled randomly → beat count stays exact, no beat is duplicated or lost, and `address` is constant within each burst.
- `enable` deasserted at beat 8 → the burst finishes, no further grant, `grant`=0. Re-enable → wptr=0 and `address`=base.
- Reset asserted at beat 8 → the next cycle shows `grant`=0, wptr=0, and both tready=0.

Source files
------------

// File: rtl/s2mm_sched_pkg.sv
// s2mm_sched_pkg: shared types, default burst geometry and ring-size clamp for the S2MM burst scheduler
package s2mm_sched_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int DEF_BURST_LEN      = 16;
  localparam int DEF_BYTES_PER_BEAT = 4;
  localparam int BURST_BYTES        = DEF_BURST_LEN * DEF_BYTES_PER_BEAT;
  function automatic logic [4:0] clamp_size(input logic [4:0] n, input logic [4:0] lo, input logic [4:0] hi);
    return (n < lo) ? lo : (n > hi) ? hi : n;
  endfunction
endpackage

// File: rtl/s2mm_ring_pointer.sv
// s2mm_ring_pointer: per-channel ring write pointer and wrap counter
// Ports: aclk/aresetn (sync, active-low); commit_i advances one burst; clear_i zeroes both;
//        size_log2_i is the already-clamped ring size; wptr_o byte offset, wraps_o wrap count.
module s2mm_ring_pointer
  import s2mm_sched_pkg::*;
#(
  parameter int AW = 32,
  parameter int BB = BURST_BYTES
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          commit_i,
  input  logic          clear_i,
  input  logic [4:0]    size_log2_i,
  output logic [AW-1:0] wptr_o,
  output logic [7:0]    wraps_o
);
  logic [AW-1:0] wptr_q, wptr_d, adv;
  logic [7:0]    wraps_q, wraps_d;
  always_comb begin
    adv     = (wptr_q + AW'(BB)) & ((AW'(1) << size_log2_i) - AW'(1));
    wptr_d  = clear_i ? '0 : commit_i ? adv : wptr_q;
    wraps_d = clear_i ? '0 : (commit_i && adv == '0) ? wraps_q + 8'd1 : wraps_q;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q  <= '0;
      wraps_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wraps_q <= wraps_d;
    end
  end
  assign wptr_o  = wptr_q;
  assign wraps_o = wraps_q;
endmodule

// File: rtl/s2mm_burst_scheduler.sv
// s2mm_burst_scheduler: round-robin merge of two AXI-Stream sources at burst boundaries with per-channel ring addressing
// Ports: aclk/aresetn (sync, active-low); enable gates new grants; chN_base/chN_size_log2 ring config;
//        s0/s1 slave streams; m_axis master stream to the writer; address burst start address;
//        chN_wptr/chN_wraps ring state for software; grant one-hot active channel (0 when idle).
module s2mm_burst_scheduler
  import s2mm_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BURST_LEN        = DEF_BURST_LEN,
  parameter int BYTES_PER_BEAT   = DEF_BYTES_PER_BEAT
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [AXI_ADDR_WIDTH-1:0]   ch0_base,
  input  logic [AXI_ADDR_WIDTH-1:0]   ch1_base,
  input  logic [4:0]                  ch0_size_log2,
  input  logic [4:0]                  ch1_size_log2,
  input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                        s0_axis_tvalid,
  output logic                        s0_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                        s1_axis_tvalid,
  output logic                        s1_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]   address,
  output logic [AXI_ADDR_WIDTH-1:0]   ch0_wptr,
  output logic [AXI_ADDR_WIDTH-1:0]   ch1_wptr,
  output logic [7:0]                  ch0_wraps,
  output logic [7:0]                  ch1_wraps,
  output logic [1:0]                  grant
);
  localparam int         AW     = AXI_ADDR_WIDTH;
  localparam int         BB     = BURST_LEN * BYTES_PER_BEAT;
  localparam int         CW     = $clog2(BURST_LEN);
  localparam logic [4:0] SZ_MIN = 5'($clog2(BB));
  localparam logic [4:0] SZ_MAX = 5'(AW - 1);
  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [4:0]      size_q, size_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d, en_q;
  logic            rise, pick1, sel, hs, done;
  always_comb begin
    rise           = enable & ~en_q;
    // ch1 wins when it is the only requester, or both request and ch0 went last
    pick1          = s1_axis_tvalid & (~s0_axis_tvalid | ~last_q);
    sel            = grant_q[1];
    m_axis_tdata   = sel ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tvalid  = (state_q == BURST) & (sel ? s1_axis_tvalid : s0_axis_tvalid);
    s0_axis_tready = (state_q == BURST) & ~sel & m_axis_tready;
    s1_axis_tready = (state_q == BURST) & sel & m_axis_tready;
    hs             = m_axis_tvalid & m_axis_tready;
    done           = hs & (cnt_q == CW'(BURST_LEN - 1));
    state_d        = state_q;
    grant_d        = grant_q;
    addr_d         = addr_q;
    size_d         = size_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    if (state_q == IDLE) begin
      if (enable & (s0_axis_tvalid | s1_axis_tvalid)) begin
        state_d = BURST;
        grant_d = pick1 ? 2'b10 : 2'b01;
        // the pointer clear on an enable rise lands this same edge, so bypass it here
        addr_d  = (pick1 ? ch1_base : ch0_base) + (rise ? '0 : (pick1 ? ch1_wptr : ch0_wptr));
        size_d  = clamp_size(pick1 ? ch1_size_log2 : ch0_size_log2, SZ_MIN, SZ_MAX);
        cnt_d   = '0;
        last_d  = pick1;
      end
    end else begin
      cnt_d   = hs ? cnt_q + CW'(1) : cnt_q;
      state_d = done ? IDLE : BURST;
      grant_d = done ? 2'b00 : grant_q;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      size_q  <= SZ_MIN;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      en_q    <= enable;
    end
  end
  s2mm_ring_pointer #(.AW(AW), .BB(BB)) u_ring0 (
    .aclk(aclk), .aresetn(aresetn), .commit_i(done & ~sel), .clear_i(rise),
    .size_log2_i(size_q), .wptr_o(ch0_wptr), .wraps_o(ch0_wraps)
  );
  s2mm_ring_pointer #(.AW(AW), .BB(BB)) u_ring1 (
    .aclk(aclk), .aresetn(aresetn), .commit_i(done & sel), .clear_i(rise),
    .size_log2_i(size_q), .wptr_o(ch1_wptr), .wraps_o(ch1_wraps)
  );
  assign address = addr_q;
  assign grant   = grant_q;
endmodule

// File: tb/tb_s2mm_burst_scheduler.sv
// tb_s2mm_burst_scheduler: randomized scoreboard bench for the two-channel burst scheduler
module tb_s2mm_burst_scheduler;
  logic        aclk = 0;
  logic        aresetn = 0;
  logic        enable = 0;
  logic [31:0] ch0_base = 0, ch1_base = 0;
  logic [4:0]  ch0_size_log2 = 8, ch1_size_log2 = 10;
  logic [31:0] s_d [2];
  logic        s_v [2];
  logic        s0_axis_tready, s1_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 0;
  logic [31:0] address, ch0_wptr, ch1_wptr;
  logic [7:0]  ch0_wraps, ch1_wraps;
  logic [1:0]  grant;

  s2mm_burst_scheduler dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .ch0_base(ch0_base), .ch1_base(ch1_base),
    .ch0_size_log2(ch0_size_log2), .ch1_size_log2(ch1_size_log2),
    .s0_axis_tdata(s_d[0]), .s0_axis_tvalid(s_v[0]), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s_d[1]), .s1_axis_tvalid(s_v[1]), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .address(address), .ch0_wptr(ch0_wptr), .ch1_wptr(ch1_wptr),
    .ch0_wraps(ch0_wraps), .ch1_wraps(ch1_wraps), .grant(grant)
  );

  always #5 aclk = ~aclk;

  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // stimulus controls
  int  gen_pct [2] = '{100, 100};
  int  left [2] = '{0, 0};
  int  hold [2] = '{0, 0};
  int  rdy_mode = 1;
  bit  pause_en = 0;
  int  phase = 0;
  logic [31:0] expq0 [$], expq1 [$];
  logic [31:0] a0q [$];
  int  gq [$];

  // reference model state
  bit          armed = 0;
  int          act_ch = -1, bcnt = 0, bursts = 0, meff = 6;
  bit          mlast = 1, men = 0;
  logic [31:0] maddr = 0;
  logic [31:0] mwptr [2] = '{0, 0};
  logic [7:0]  mwraps [2] = '{0, 0};
  bit          acc [2] = '{0, 0};

  initial begin
    s_v[0] = 0; s_v[1] = 0; s_d[0] = 0; s_d[1] = 0;
  end

  // sources: hold tvalid until accepted; each generated beat is pushed to its channel's expectation queue
  initial forever begin
    @(posedge aclk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) s_v[c] = 0;
      if (c == 1 && pause_en && acc[1] && act_ch == 1 && bcnt == 5) begin
        hold[1] = 10;
        pause_en = 0;
      end
      if (hold[c] > 0) hold[c]--;
      else if (!s_v[c] && left[c] > 0 && $urandom_range(99) < gen_pct[c]) begin
        s_d[c] = $urandom;
        s_v[c] = 1;
        left[c]--;
        if (c == 0) expq0.push_back(s_d[c]); else expq1.push_back(s_d[c]);
      end
    end
    m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
  end

  // monitor: compare DUT against the model, then advance the model by one clock
  always @(negedge aclk) begin
    logic [1:0]  eg;
    logic [31:0] d;
    int          c, sz;
    bit          hs, rise;
    if (armed) begin
      eg = (act_ch < 0) ? 2'b00 : (act_ch == 0) ? 2'b01 : 2'b10;
      chk("grant", grant, eg);
      chk("address", address, maddr);
      chk("ch0_wptr", ch0_wptr, mwptr[0]);
      chk("ch1_wptr", ch1_wptr, mwptr[1]);
      chk("ch0_wraps", ch0_wraps, mwraps[0]);
      chk("ch1_wraps", ch1_wraps, mwraps[1]);
      if (act_ch < 0) begin
        chk("m_tvalid_idle", m_axis_tvalid, 0);
        chk("s0_tready_idle", s0_axis_tready, 0);
        chk("s1_tready_idle", s1_axis_tready, 0);
      end else begin
        chk("m_tvalid_pass", m_axis_tvalid, s_v[act_ch]);
        chk("sel_tready", (act_ch == 0) ? s0_axis_tready : s1_axis_tready, m_axis_tready);
        chk("other_tready", (act_ch == 0) ? s1_axis_tready : s0_axis_tready, 0);
      end
    end
    acc[0] = aresetn && s_v[0] && s0_axis_tready;
    acc[1] = aresetn && s_v[1] && s1_axis_tready;
    hs = aresetn && m_axis_tvalid && m_axis_tready;
    if (!aresetn) begin
      armed = 1; act_ch = -1; bcnt = 0; mlast = 1; men = 0; maddr = 0;
      mwptr[0] = 0; mwptr[1] = 0; mwraps[0] = 0; mwraps[1] = 0;
    end else if (armed) begin
      rise = enable && !men;
      if (act_ch < 0) begin
        if (enable && (s_v[0] || s_v[1])) begin
          c = (s_v[0] && s_v[1]) ? (mlast ? 0 : 1) : (s_v[0] ? 0 : 1);
          mlast = (c == 1);
          act_ch = c;
          bcnt = 0;
          maddr = (c == 1 ? ch1_base : ch0_base) + (rise ? 32'd0 : mwptr[c]);
          sz = (c == 1) ? int'(ch1_size_log2) : int'(ch0_size_log2);
          meff = (sz < 6) ? 6 : (sz > 31) ? 31 : sz;
          gq.push_back(c);
          if (c == 0 && phase == 1) a0q.push_back(maddr);
        end
      end else if (hs) begin
        if ((act_ch == 0 ? expq0.size() : expq1.size()) == 0) begin
          errs++; checks++;
          $display("FAIL beat_unexpected: got %0h expected none", m_axis_tdata);
        end else begin
          d = (act_ch == 0) ? expq0.pop_front() : expq1.pop_front();
          chk("tdata", m_axis_tdata, d);
        end
        bcnt++;
        if (bcnt == 16) begin
          mwptr[act_ch] = 32'((64'(mwptr[act_ch]) + 64) % (64'd1 << meff));
          if (mwptr[act_ch] == 0) mwraps[act_ch]++;
          act_ch = -1;
          bursts++;
        end
      end
      if (rise) begin
        mwptr[0] = 0; mwptr[1] = 0; mwraps[0] = 0; mwraps[1] = 0;
      end
      men = enable;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_bursts(input int n, input string nm);
    int i;
    for (i = 0; i < 3000 && bursts < n; i++) cycles(1);
    if (bursts < n) begin
      errs++; checks++;
      $display("FAIL %s timeout: got %0d bursts expected %0d", nm, bursts, n);
    end
  endtask

  task automatic wait_beat8(input string nm);
    int i;
    for (i = 0; i < 3000 && !(act_ch >= 0 && bcnt == 8); i++) cycles(1);
    if (!(act_ch >= 0 && bcnt == 8)) begin
      errs++; checks++;
      $display("FAIL %s timeout: got beat %0d expected 8", nm, bcnt);
    end
  endtask

  logic [31:0] exp_a [5];
  int i;
  initial begin
    exp_a = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080, 32'h1000_00C0, 32'h1000_0000};
    ch0_base = 32'h1000_0000; ch0_size_log2 = 8;
    ch1_base = 32'h2000_0000; ch1_size_log2 = 10;
    cycles(3);
    aresetn = 1;
    cycles(1);
    chk("reset_grant", grant, 0);
    chk("reset_address", address, 0);
    chk("reset_m_tvalid", m_axis_tvalid, 0);
    // ch0 only: five bursts walk a 256-byte ring once round
    phase = 1;
    enable = 1;
    left[0] = 80;
    wait_bursts(5, "ch0_only");
    cycles(3);
    phase = 0;
    chk("ch0_wraps_after5", ch0_wraps, 1);
    chk("ch0_wptr_after5", ch0_wptr, 32'h40);
    chk("ch0_addr_count", a0q.size(), 5);
    for (int k = 0; k < 5 && k < a0q.size(); k++) chk("ch0_addr_seq", a0q[k], exp_a[k]);
    // both channels always valid: grants must alternate
    gq.delete();
    left[0] = 64; left[1] = 64;
    wait_bursts(13, "both_valid");
    chk("alt_grants", gq.size() >= 8, 1);
    for (int k = 1; k < 8 && k < gq.size(); k++) chk("alternation", gq[k], 1 - gq[k-1]);
    cycles(5);
    // ch1 stalls mid-burst; ch0 must stay blocked while ch1 keeps the grant
    left[0] = 32; left[1] = 32; pause_en = 1;
    wait_bursts(17, "pause");
    cycles(5);
    // random backpressure, gaps, ring sizes and bases
    rdy_mode = 2; gen_pct[0] = 60; gen_pct[1] = 60;
    left[0] = 400; left[1] = 400;
    for (int k = 0; k < 30; k++) begin
      ch0_size_log2 = 5'($urandom_range(12));
      ch1_size_log2 = 5'($urandom_range(12));
      ch0_base = $urandom & ~((32'd1 << ch0_size_log2) - 1) & 32'hFFFF_F000;
      ch1_base = $urandom & ~((32'd1 << ch1_size_log2) - 1) & 32'hFFFF_F000;
      cycles(50);
    end
    // disable at beat 8: burst completes, then no new grant
    rdy_mode = 1; gen_pct[0] = 100; gen_pct[1] = 100;
    left[0] = 200; left[1] = 200;
    wait_beat8("en_drop");
    enable = 0;
    cycles(30);
    chk("disabled_grant", grant, 0);
    chk("disabled_m_tvalid", m_axis_tvalid, 0);
    enable = 1;
    for (i = 0; i < 20 && grant == 0; i++) cycles(1);
    chk("reenable_granted", grant != 0, 1);
    chk("reenable_addr", address, grant == 2'b10 ? ch1_base : ch0_base);
    // reset at beat 8 abandons the burst
    wait_beat8("rst_mid");
    aresetn = 0; rdy_mode = 0;
    cycles(1);
    aresetn = 1;
    chk("rst_grant", grant, 0);
    chk("rst_ch0_wptr", ch0_wptr, 0);
    chk("rst_ch1_wptr", ch1_wptr, 0);
    chk("rst_s0_tready", s0_axis_tready, 0);
    chk("rst_s1_tready", s1_axis_tready, 0);
    rdy_mode = 1;
    cycles(100);
    left[0] = 0; left[1] = 0;
    cycles(200);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
